// File: rtl/axil_rd_arbiter.sv
// Shares one AXI-lite read master among S_COUNT requesters, one transaction at a time.
// Round-robin grant in IDLE, then ADDR -> DATA -> RESP before the next grant.
module axil_rd_arbiter #(
   parameter int S_COUNT    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [S_COUNT*ADDR_WIDTH-1:0]   s_axil_araddr,
   input  logic [S_COUNT*3-1:0]            s_axil_arprot,
   input  logic [S_COUNT-1:0]              s_axil_arvalid,
   output logic [S_COUNT-1:0]              s_axil_arready,
   output logic [S_COUNT*DATA_WIDTH-1:0]   s_axil_rdata,
   output logic [S_COUNT*2-1:0]            s_axil_rresp,
   output logic [S_COUNT-1:0]              s_axil_rvalid,
   input  logic [S_COUNT-1:0]              s_axil_rready,
   output logic [ADDR_WIDTH-1:0]           m_axil_araddr,
   output logic [2:0]                      m_axil_arprot,
   output logic                            m_axil_arvalid,
   input  logic                            m_axil_arready,
   input  logic [DATA_WIDTH-1:0]           m_axil_rdata,
   input  logic [1:0]                      m_axil_rresp,
   input  logic                            m_axil_rvalid,
   output logic                            m_axil_rready,
   output logic                            busy
);

   localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
   localparam logic [IDX_W:0] S_CNT = (IDX_W + 1)'(S_COUNT);
   localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(S_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        grant_q, grant_d;
   logic [IDX_W-1:0]        last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [2:0]              arprot_q, arprot_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic                    m_arvalid_q, m_arvalid_d;
   logic                    m_rready_q, m_rready_d;
   logic [S_COUNT-1:0]      s_rvalid_q, s_rvalid_d;

   logic                    arb_valid;
   logic [IDX_W-1:0]        arb_idx;
   logic [IDX_W:0]          scan_idx;
   logic [ADDR_WIDTH-1:0]   arb_addr;
   logic [2:0]              arb_prot;
   logic                    s_rready_g;

   // Scan starts one past the last served port and wraps; the extra bit avoids overflow before the wrap.
   always_comb begin
      arb_valid = 1'b0;
      arb_idx   = '0;
      scan_idx  = '0;
      for (int i = 1; i <= S_COUNT; i++) begin
         scan_idx = {1'b0, last_grant_q} + (IDX_W + 1)'(i);
         if (scan_idx >= S_CNT) begin
            scan_idx = scan_idx - S_CNT;
         end
         if (!arb_valid && s_axil_arvalid[scan_idx[IDX_W-1:0]]) begin
            arb_valid = 1'b1;
            arb_idx   = scan_idx[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      arb_addr       = '0;
      arb_prot       = '0;
      s_axil_arready = '0;
      for (int p = 0; p < S_COUNT; p++) begin
         if (arb_idx == IDX_W'(p)) begin
            arb_addr = s_axil_araddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            arb_prot = s_axil_arprot[p*3 +: 3];
         end
         s_axil_arready[p] = !rst && (state_q == IDLE) && arb_valid && (arb_idx == IDX_W'(p));
      end
   end

   assign s_rready_g = s_axil_rready[grant_q];

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      araddr_d     = araddr_q;
      arprot_d     = arprot_q;
      rdata_d      = rdata_q;
      rresp_d      = rresp_q;
      m_arvalid_d  = m_arvalid_q;
      m_rready_d   = m_rready_q;
      s_rvalid_d   = s_rvalid_q;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d     = arb_idx;
               araddr_d    = arb_addr;
               arprot_d    = arb_prot;
               m_arvalid_d = 1'b1;
               state_d     = ADDR;
            end
         end
         ADDR: begin
            if (m_axil_arready) begin
               m_arvalid_d = 1'b0;
               m_rready_d  = 1'b1;
               state_d     = DATA;
            end
         end
         DATA: begin
            if (m_axil_rvalid && m_rready_q) begin
               rdata_d    = m_axil_rdata;
               rresp_d    = m_axil_rresp;
               m_rready_d = 1'b0;
               for (int p = 0; p < S_COUNT; p++) begin
                  s_rvalid_d[p] = (grant_q == IDX_W'(p));
               end
               state_d    = RESP;
            end
         end
         RESP: begin
            if (s_rready_g) begin
               s_rvalid_d   = '0;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_PORT;
         m_arvalid_q  <= 1'b0;
         m_rready_q   <= 1'b0;
         s_rvalid_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         m_arvalid_q  <= m_arvalid_d;
         m_rready_q   <= m_rready_d;
         s_rvalid_q   <= s_rvalid_d;
      end
   end

   // Payload registers are only consumed under a valid, so they carry no reset.
   always_ff @(posedge clk) begin
      araddr_q <= araddr_d;
      arprot_q <= arprot_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
   end

   assign m_axil_araddr  = araddr_q;
   assign m_axil_arprot  = arprot_q;
   assign m_axil_arvalid = m_arvalid_q;
   assign m_axil_rready  = m_rready_q;
   assign s_axil_rvalid  = s_rvalid_q;
   assign s_axil_rdata   = {S_COUNT{rdata_q}};
   assign s_axil_rresp   = {S_COUNT{rresp_q}};
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Bench for axil_rd_arbiter: scenario tasks drive both sides cycle by cycle,
// expected responses go through a queue and are checked when s_axil_rvalid rises.
module tb_axil_rd_arbiter;

   localparam int S_COUNT = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int W       = 4 + DW + 2;

   logic                    clk;
   logic                    rst;
   logic [S_COUNT*AW-1:0]   s_axil_araddr;
   logic [S_COUNT*3-1:0]    s_axil_arprot;
   logic [S_COUNT-1:0]      s_axil_arvalid;
   logic [S_COUNT-1:0]      s_axil_arready;
   logic [S_COUNT*DW-1:0]   s_axil_rdata;
   logic [S_COUNT*2-1:0]    s_axil_rresp;
   logic [S_COUNT-1:0]      s_axil_rvalid;
   logic [S_COUNT-1:0]      s_axil_rready;
   logic [AW-1:0]           m_axil_araddr;
   logic [2:0]              m_axil_arprot;
   logic                    m_axil_arvalid;
   logic                    m_axil_arready;
   logic [DW-1:0]           m_axil_rdata;
   logic [1:0]              m_axil_rresp;
   logic                    m_axil_rvalid;
   logic                    m_axil_rready;
   logic                    busy;

   int compared   = 0;
   int mismatched = 0;
   int model_last = S_COUNT - 1;
   logic [W-1:0]  exp_q[$];
   logic [AW-1:0] req_addr[S_COUNT];
   logic [2:0]    req_prot[S_COUNT];

   axil_rd_arbiter #(.S_COUNT(S_COUNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arprot  (s_axil_arprot),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready),
      .m_axil_araddr  (m_axil_araddr),
      .m_axil_arprot  (m_axil_arprot),
      .m_axil_arvalid (m_axil_arvalid),
      .m_axil_arready (m_axil_arready),
      .m_axil_rdata   (m_axil_rdata),
      .m_axil_rresp   (m_axil_rresp),
      .m_axil_rvalid  (m_axil_rvalid),
      .m_axil_rready  (m_axil_rready),
      .busy           (busy)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, compared=%0d", compared);
      $fatal;
   end

   // Inputs change at posedge+1; outputs are sampled at the following negedge.
   task automatic set_req(input int p, input logic [AW-1:0] a, input logic [2:0] pr);
      req_addr[p] = a;
      req_prot[p] = pr;
      s_axil_araddr[p*AW +: AW] = a;
      s_axil_arprot[p*3 +: 3]   = pr;
      s_axil_arvalid[p]         = 1'b1;
   endtask

   function automatic int rr_pick(input logic [S_COUNT-1:0] m, input int last);
      int idx;
      for (int i = 1; i <= S_COUNT; i++) begin
         idx = (last + i) % S_COUNT;
         if (m[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic run_txn(input int p, input logic [DW-1:0] data, input logic [1:0] resp,
                          input int ar_delay, input int r_delay, input bit keep,
                          input bit pulse, input bit immediate);
      logic [S_COUNT-1:0] oh;
      logic [W-1:0]       e;
      logic [S_COUNT-1:0] e_oh;
      int                 waited;
      oh = 4'b0001 << p;
      waited = 0;
      @(negedge clk);
      while (s_axil_arready == '0 && waited < 20) begin
         @(posedge clk); #1;
         @(negedge clk);
         waited++;
      end
      compared++;
      if (s_axil_arready !== oh) begin
         mismatched++;
         $display("FAIL grant: arready=%b expected %b (waited %0d)", s_axil_arready, oh, waited);
         return;
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL idle_busy: busy=%b expected 0 while granting", busy);
      end
      if (immediate) begin
         compared++;
         if (waited != 0) begin
            mismatched++;
            $display("FAIL idle_gap: waited %0d cycles expected 0", waited);
         end
      end
      @(posedge clk); #1;
      if (!keep) s_axil_arvalid[p] = 1'b0;
      @(negedge clk);
      compared++;
      if ({m_axil_arvalid, busy, s_axil_arready, m_axil_arprot, m_axil_araddr} !==
          {1'b1, 1'b1, 4'b0000, req_prot[p], req_addr[p]}) begin
         mismatched++;
         $display("FAIL ar_issue: arvalid=%b busy=%b arready=%b prot=%h addr=%h expected 1 1 0000 %h %h",
                  m_axil_arvalid, busy, s_axil_arready, m_axil_arprot, m_axil_araddr, req_prot[p], req_addr[p]);
      end
      for (int d = 0; d < ar_delay; d++) begin
         @(posedge clk); #1;
         m_axil_rvalid = pulse && (d == 0);
         m_axil_rdata  = 32'hBAD0_0000 | 32'(d);
         m_axil_rresp  = 2'b11;
         @(negedge clk);
         compared++;
         if ({m_axil_arvalid, m_axil_rready, m_axil_araddr} !== {1'b1, 1'b0, req_addr[p]}) begin
            mismatched++;
            $display("FAIL ar_hold: arvalid=%b rready=%b addr=%h expected 1 0 %h",
                     m_axil_arvalid, m_axil_rready, m_axil_araddr, req_addr[p]);
         end
      end
      @(posedge clk); #1;
      m_axil_rvalid  = 1'b0;
      m_axil_arready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      m_axil_arready = 1'b0;
      m_axil_rvalid  = 1'b1;
      m_axil_rdata   = data;
      m_axil_rresp   = resp;
      exp_q.push_back({4'(p), data, resp});
      @(negedge clk);
      compared++;
      if ({m_axil_arvalid, m_axil_rready, s_axil_rvalid} !== {1'b0, 1'b1, 4'b0000}) begin
         mismatched++;
         $display("FAIL data_phase: arvalid=%b rready=%b s_rvalid=%b expected 0 1 0000",
                  m_axil_arvalid, m_axil_rready, s_axil_rvalid);
      end
      @(posedge clk); #1;
      m_axil_rvalid = 1'b0;
      m_axil_rdata  = $urandom;
      m_axil_rresp  = 2'b01;
      @(negedge clk);
      compared++;
      if ({m_axil_rready, s_axil_arready} !== {1'b0, 4'b0000}) begin
         mismatched++;
         $display("FAIL resp_ctrl: m_rready=%b arready=%b expected 0 0000", m_axil_rready, s_axil_arready);
      end
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL scoreboard: response seen with empty expected queue");
         return;
      end
      e    = exp_q.pop_front();
      e_oh = 4'b0001 << e[W-1 -: 4];
      if ({s_axil_rvalid, s_axil_rdata[p*DW +: DW], s_axil_rresp[p*2 +: 2]} !== {e_oh, e[DW+1:2], e[1:0]}) begin
         mismatched++;
         $display("FAIL resp_data: rvalid=%b data=%h resp=%b expected %b %h %b",
                  s_axil_rvalid, s_axil_rdata[p*DW +: DW], s_axil_rresp[p*2 +: 2], e_oh, e[DW+1:2], e[1:0]);
      end
      for (int d = 0; d < r_delay; d++) begin
         @(posedge clk); #1;
         @(negedge clk);
         compared++;
         if ({s_axil_rvalid, s_axil_rdata[p*DW +: DW], s_axil_rresp[p*2 +: 2]} !== {e_oh, e[DW+1:2], e[1:0]}) begin
            mismatched++;
            $display("FAIL resp_hold: rvalid=%b data=%h resp=%b expected %b %h %b",
                     s_axil_rvalid, s_axil_rdata[p*DW +: DW], s_axil_rresp[p*2 +: 2], e_oh, e[DW+1:2], e[1:0]);
         end
      end
      @(posedge clk); #1;
      s_axil_rready[p] = 1'b1;
      @(posedge clk); #1;
      s_axil_rready[p] = 1'b0;
      model_last = p;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = '0; s_axil_rready = '0;
      m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;
      #1;
      set_req(0, 32'h0000_0010, 3'b000);
      repeat (2) @(negedge clk);
      compared++;
      if ({s_axil_arready, s_axil_rvalid, m_axil_arvalid, m_axil_rready, busy} !== 11'b0) begin
         mismatched++;
         $display("FAIL reset_state: arready=%b rvalid=%b m_arvalid=%b m_rready=%b busy=%b expected all 0",
                  s_axil_arready, s_axil_rvalid, m_axil_arvalid, m_axil_rready, busy);
      end
      s_axil_arvalid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_last = S_COUNT - 1;
      exp_q.delete();
   endtask

   task automatic test_all_ports();
      for (int p = 0; p < S_COUNT; p++) set_req(p, 32'h1000 + 32'(p * 4), 3'(p));
      run_txn(0, 32'hA000_0000, 2'b00, 0, 0, 0, 0, 0);
      run_txn(1, 32'hA000_0001, 2'b00, 1, 0, 0, 0, 1);
      run_txn(2, 32'hA000_0002, 2'b00, 0, 1, 0, 0, 1);
      run_txn(3, 32'hA000_0003, 2'b00, 0, 0, 0, 0, 1);
   endtask

   task automatic test_single();
      set_req(2, 32'h0000_0040, 3'b010);
      run_txn(2, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0);
   endtask

   task automatic test_alternating();
      set_req(1, 32'h0000_0100, 3'b001);
      run_txn(1, 32'h1111_0000, 2'b00, 0, 0, 0, 0, 0);
      set_req(1, 32'h0000_0104, 3'b001);
      set_req(3, 32'h0000_0300, 3'b011);
      run_txn(3, 32'h3333_0001, 2'b00, 0, 0, 1, 0, 0);
      run_txn(1, 32'h1111_0002, 2'b00, 0, 0, 1, 0, 1);
      run_txn(3, 32'h3333_0003, 2'b00, 0, 0, 0, 0, 1);
      run_txn(1, 32'h1111_0004, 2'b00, 0, 0, 0, 0, 1);
   endtask

   task automatic test_delays();
      set_req(0, 32'h0000_0ABC, 3'b101);
      run_txn(0, 32'hCAFE_F00D, 2'b00, 5, 3, 0, 1, 0);
   endtask

   task automatic test_error_resp();
      set_req(3, 32'h0000_0F00, 3'b110);
      run_txn(3, 32'h5A5A_5A5A, 2'b10, 0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      set_req(0, 32'h0000_2000, 3'b000);
      run_txn(0, 32'h0B2B_0000, 2'b00, 0, 0, 1, 0, 0);
      run_txn(0, 32'h0B2B_0001, 2'b01, 0, 0, 1, 0, 1);
      run_txn(0, 32'h0B2B_0002, 2'b00, 0, 0, 0, 0, 1);
   endtask

   task automatic test_reset_mid_txn();
      set_req(2, 32'h0000_0777, 3'b111);
      @(negedge clk);
      @(posedge clk); #1;
      s_axil_arvalid[2] = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      m_axil_arready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      m_axil_arready = 1'b0;
      m_axil_rvalid  = 1'b1;
      m_axil_rdata   = 32'h57A1_E000;
      @(negedge clk);
      compared++;
      if (m_axil_rready !== 1'b1) begin
         mismatched++;
         $display("FAIL pre_reset_data: m_rready=%b expected 1", m_axil_rready);
      end
      #1;
      rst = 1'b1;
      #1;
      compared++;
      if ({s_axil_arready, s_axil_rvalid, m_axil_arvalid, m_axil_rready, busy} !== 11'b0) begin
         mismatched++;
         $display("FAIL async_reset: arready=%b rvalid=%b m_arvalid=%b m_rready=%b busy=%b expected all 0",
                  s_axil_arready, s_axil_rvalid, m_axil_arvalid, m_axil_rready, busy);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_axil_rvalid = 1'b0;
      model_last = S_COUNT - 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         compared++;
         if ({s_axil_rvalid, busy} !== 5'b0) begin
            mismatched++;
            $display("FAIL stale_resp: rvalid=%b busy=%b expected 0000 0", s_axil_rvalid, busy);
         end
         @(posedge clk); #1;
      end
      set_req(1, 32'h0000_0111, 3'b001);
      set_req(3, 32'h0000_0333, 3'b011);
      run_txn(1, 32'h0001_AAAA, 2'b00, 0, 0, 0, 0, 0);
      run_txn(3, 32'h0003_BBBB, 2'b00, 0, 0, 0, 0, 1);
   endtask

   task automatic test_random();
      logic [S_COUNT-1:0] mask;
      int p;
      bit first;
      for (int t = 0; t < 8; t++) begin
         mask = 4'($urandom_range(1, 15));
         for (int b = 0; b < S_COUNT; b++) begin
            if (mask[b]) set_req(b, $urandom, 3'($urandom_range(0, 7)));
         end
         first = 1'b1;
         while (mask != '0) begin
            p = rr_pick(mask, model_last);
            run_txn(p, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                    $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)), !first);
            mask[p] = 1'b0;
            first = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_ports();
      test_single();
      test_alternating();
      test_delays();
      test_error_resp();
      test_back_to_back();
      test_reset_mid_txn();
      test_random();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL leftover: %0d expected responses never delivered, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
